cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Sits between the functional units of the execute stage and the EX/IC pipeline register feeding stage_ic.
- Each of N_FU functional units offers at most one completed EX_IC_PACKET per cycle, but there is only one CDB.
- The block buffers results in a small per-unit FIFO and grants one packet per cycle, round-robin.
- It drives the registered ex_ic_reg that stage_ic converts into the CDB broadcast and the ROB completion.

Parameters:
- N_FU, 4, number of functional-unit result channels (>=2).
- DEPTH, 2, entries per channel FIFO (>=1, power of two).

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- squash  in  1  branch-mispredict flush from retire.
- fu_packet  in  N_FU x $bits(EX_IC_PACKET)  per-unit result; the .valid field marks an offer.
- fu_ready  out  N_FU  channel i can accept this cycle.
- ex_ic_reg  out  $bits(EX_IC_PACKET)  registered winner; .valid=0 means no completion.
- grant_idx  out  $clog2(N_FU)  channel that produced the current ex_ic_reg (debug).

Behaviour:
- Reset (reset==0 at posedge):
  - All FIFOs empty; rr_ptr=0.
  - ex_ic_reg all fields 0 (valid=0); grant_idx=0.
  - fu_ready reads all 1 from the first cycle after reset.
- Push:
  - fu_ready[i] = (count[i] < DEPTH). It depends only on registered count, with no combinational path from grant.
  - Push occurs when fu_packet[i].valid && fu_ready[i]. A packet offered while not ready is dropped by contract; the FU must hold it.
- Grant, every cycle:
  - Scan channels rr_ptr, rr_ptr+1, ... mod N_FU and pick the first non-empty FIFO.
  - Pop its head and register it into ex_ic_reg with valid=1; grant_idx<=winner; rr_ptr<=(winner+1) mod N_FU.
  - If no FIFO is non-empty: ex_ic_reg.valid<=0, other fields hold, rr_ptr holds.
- Latency: a packet pushed at edge t is at the head in cycle t+1 and, if granted, appears in ex_ic_reg in cycle t+2. Minimum latency is 2 edges (see Optional Feature).
- Ordering: FIFO order is preserved within a channel. No ordering is guaranteed across channels.
- Same-channel push and pop in one cycle: count unchanged, legal even at count==DEPTH. fu_ready was already 0 in that case, so no push happens.
- Wrap-around: read/write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Fairness: a continuously non-empty channel is granted at least once every N_FU cycles.
- Squash (reset==1, squash==1):
  - All FIFOs are emptied and rr_ptr<=0.
  - ex_ic_reg.valid<=0; no grant that cycle.
  - Pushes offered that cycle are discarded.
- Priority: reset overrides squash. A reset asserted mid-stream discards all buffered packets.

Optional Feature:
- Macro: CDB_ARB_BYPASS_EN.
- Defined:
  - A channel whose FIFO is empty and whose FU offers a valid packet counts as a candidate in the same scan.
  - If it wins, the packet goes directly into ex_ic_reg without being written to the FIFO, giving 1-edge latency.
  - If it loses, it is pushed as normal.
  - fu_ready is unchanged.
- Undefined: only FIFO heads are candidates; latency as stated above.

Decomposition:
- Shared package (sys_defs.svh):
  - EX_IC_PACKET (existing).
  - `define N_FU and `define CDB_FIFO_DEPTH, used as the parameter defaults.
- Sub-module cdb_fu_fifo: one instance per channel.
  - Ports: clock, reset, flush, push, push_data, pop, head, empty, full.

Test Plan:
- Reset, then idle 5 cycles -> ex_ic_reg.valid=0, fu_ready=4'b1111, grant_idx=0.
- Single push on channel 2 (rob_idx=5) at edge t -> ex_ic_reg.valid=1, rob_idx=5, grant_idx=2 in cycle t+2 only; valid=0 at t+3. With bypass: in cycle t+1.
- All 4 channels push every cycle with DEPTH=2 -> grant_idx sequence 0,1,2,3,0,...; no channel is granted twice within 4 cycles; fu_ready toggles to keep each count<=2; no packet lost (per-channel rob_idx sequence matches).
- Fill channel 1 with 2 packets, hold fu_packet[1].valid -> fu_ready[1]=0; a pop frees a slot next cycle and the held packet is accepted exactly once.
- 3 packets buffered, assert squash with a new offer on channel 0 -> next cycle ex_ic_reg.valid=0 and all FIFOs empty; the squashed-cycle offer never appears.
- reset=0 for one cycle while 2 channels are full -> after release, valid=0, fu_ready all 1, rr_ptr restarts at channel 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default sizing for the CDB arbiter slice.
// EX_IC_PACKET is the execute-to-issue/complete result payload used across the execute stage.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_N_FU       = 4;
    localparam int unsigned CDB_FIFO_DEPTH = 2;

    localparam int unsigned ROB_IDX_W = 5;
    localparam int unsigned PRN_W     = 6;
    localparam int unsigned XLEN      = 32;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PRN_W-1:0]     dest_prn;
        logic [XLEN-1:0]      result;
        logic                 take_branch;
    } EX_IC_PACKET;

    // (base + ofs) mod n, for ofs < n and base < n
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned ofs,
                                            input int unsigned n);
        int unsigned s;
        s = base + ofs;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-functional-unit result FIFO; flush empties it in one cycle.
module cdb_fu_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = CDB_FIFO_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  EX_IC_PACKET push_data,
    input  logic        pop,
    output EX_IC_PACKET head,
    output logic        empty,
    output logic        full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    EX_IC_PACKET      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = reset && !flush && push && !full;
    assign do_pop  = reset && !flush && pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Simultaneous push and pop leave the occupancy unchanged
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging per-FU result FIFOs onto the single CDB register ex_ic_reg.
// Optional macro CDB_ARB_BYPASS_EN lets an empty channel's live offer win directly (1-edge latency).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_FU  = CDB_N_FU,
    parameter int unsigned DEPTH = CDB_FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  EX_IC_PACKET [N_FU-1:0]   fu_packet,
    output logic [N_FU-1:0]          fu_ready,
    output EX_IC_PACKET              ex_ic_reg,
    output logic [$clog2(N_FU)-1:0]  grant_idx
);

    localparam int unsigned IDX_W = $clog2(N_FU);

    EX_IC_PACKET [N_FU-1:0] head;
    logic [N_FU-1:0]        empty;
    logic [N_FU-1:0]        full;
    logic [N_FU-1:0]        push;
    logic [N_FU-1:0]        pop;
    logic [N_FU-1:0]        cand;

    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       rr_nxt;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       grant_nxt;
    logic                   found;
    EX_IC_PACKET            pkt_nxt;

    for (genvar g = 0; g < N_FU; g++) begin : g_fifo
        cdb_fu_fifo #(
            .DEPTH(DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .flush     (squash),
            .push      (push[g]),
            .push_data (fu_packet[g]),
            .pop       (pop[g]),
            .head      (head[g]),
            .empty     (empty[g]),
            .full      (full[g])
        );
    end

    // Ready depends only on registered occupancy
    assign fu_ready = ~full;

    always_comb begin
        cand = '0;
        for (int i = 0; i < N_FU; i++) begin
`ifdef CDB_ARB_BYPASS_EN
            cand[i] = !empty[i] || fu_packet[i].valid;
`else
            cand[i] = !empty[i];
`endif
        end
    end

    // First candidate at or after rr_ptr, wrapping
    always_comb begin : scan
        logic [IDX_W-1:0] idx;
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N_FU; k++) begin
            idx = IDX_W'(rr_wrap(32'(rr_ptr), k, N_FU));
            if (!found && cand[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        rr_nxt        = rr_ptr;
        grant_nxt     = grant_idx;
        pkt_nxt       = ex_ic_reg;
        pkt_nxt.valid = 1'b0;
        push          = '0;
        pop           = '0;
        if (squash) begin
            rr_nxt = '0;
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                push[i] = fu_packet[i].valid && fu_ready[i];
            end
            if (found) begin
                rr_nxt    = (win_idx == IDX_W'(N_FU - 1)) ? '0 : win_idx + 1'b1;
                grant_nxt = win_idx;
`ifdef CDB_ARB_BYPASS_EN
                if (empty[win_idx]) begin
                    pkt_nxt         = fu_packet[win_idx];
                    push[win_idx]   = 1'b0;
                end else begin
                    pkt_nxt         = head[win_idx];
                    pop[win_idx]    = 1'b1;
                end
`else
                pkt_nxt      = head[win_idx];
                pop[win_idx] = 1'b1;
`endif
                pkt_nxt.valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr    <= '0;
            ex_ic_reg <= '0;
            grant_idx <= '0;
        end else begin
            rr_ptr    <= rr_nxt;
            ex_ic_reg <= pkt_nxt;
            grant_idx <= grant_nxt;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default build): round-robin table plus hold, squash and reset sequences.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned NV = 18;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 squash;
    EX_IC_PACKET [N-1:0]  fu_packet;
    logic [N-1:0]         fu_ready;
    EX_IC_PACKET          ex_ic_reg;
    logic [1:0]           grant_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] offer;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [4:0] exp_rob;
        logic [1:0] exp_gidx;
    } vec_t;

    vec_t       vecs [NV];
    logic [2:0] seq [N];
    logic [3:0] rdy_now;

    cdb_arbiter #(
        .N_FU  (N),
        .DEPTH (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .fu_packet (fu_packet),
        .fu_ready  (fu_ready),
        .ex_ic_reg (ex_ic_reg),
        .grant_idx (grant_idx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] result_of(input logic [4:0] rob);
        return {27'h0, rob} ^ 32'hA5A5_0000;
    endfunction

    task automatic offer(input int ch, input logic [4:0] rob);
        fu_packet[ch].valid       = 1'b1;
        fu_packet[ch].rob_idx     = rob;
        fu_packet[ch].dest_prn    = 6'(rob) + 6'd1;
        fu_packet[ch].result      = result_of(rob);
        fu_packet[ch].take_branch = rob[0];
    endtask

    task automatic expect_state(input string tag, input logic v, input logic [4:0] rob,
                                input logic [1:0] g, input logic [3:0] rdy);
        chk({tag, ".valid"}, 32'(ex_ic_reg.valid), 32'(v));
        chk({tag, ".rob"},   32'(ex_ic_reg.rob_idx), 32'(rob));
        chk({tag, ".grant"}, 32'(grant_idx), 32'(g));
        chk({tag, ".ready"}, 32'(fu_ready), 32'(rdy));
    endtask

    initial begin
        // All channels offer every cycle (holding when not ready), then drain
        vecs[0]  = '{4'b1111, 4'b1111, 1'b0, 5'd0,  2'd0};
        vecs[1]  = '{4'b1111, 4'b0001, 1'b1, 5'd0,  2'd0};
        vecs[2]  = '{4'b1111, 4'b0010, 1'b1, 5'd8,  2'd1};
        vecs[3]  = '{4'b1111, 4'b0100, 1'b1, 5'd16, 2'd2};
        vecs[4]  = '{4'b1111, 4'b1000, 1'b1, 5'd24, 2'd3};
        vecs[5]  = '{4'b1111, 4'b0001, 1'b1, 5'd1,  2'd0};
        vecs[6]  = '{4'b1111, 4'b0010, 1'b1, 5'd9,  2'd1};
        vecs[7]  = '{4'b1111, 4'b0100, 1'b1, 5'd17, 2'd2};
        vecs[8]  = '{4'b1111, 4'b1000, 1'b1, 5'd25, 2'd3};
        vecs[9]  = '{4'b1111, 4'b0001, 1'b1, 5'd2,  2'd0};
        vecs[10] = '{4'b0000, 4'b0011, 1'b1, 5'd10, 2'd1};
        vecs[11] = '{4'b0000, 4'b0111, 1'b1, 5'd18, 2'd2};
        vecs[12] = '{4'b0000, 4'b1111, 1'b1, 5'd26, 2'd3};
        vecs[13] = '{4'b0000, 4'b1111, 1'b1, 5'd3,  2'd0};
        vecs[14] = '{4'b0000, 4'b1111, 1'b1, 5'd11, 2'd1};
        vecs[15] = '{4'b0000, 4'b1111, 1'b1, 5'd19, 2'd2};
        vecs[16] = '{4'b0000, 4'b1111, 1'b1, 5'd27, 2'd3};
        vecs[17] = '{4'b0000, 4'b1111, 1'b0, 5'd27, 2'd3};

        reset     = 1'b0;
        squash    = 1'b0;
        fu_packet = '0;
        repeat (2) tick();
        expect_state("rst", 1'b0, 5'd0, 2'd0, 4'b1111);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_state($sformatf("idle%0d", i), 1'b0, 5'd0, 2'd0, 4'b1111);
        end

        for (int c = 0; c < N; c++) seq[c] = 3'd0;
        for (int i = 0; i < NV; i++) begin
            rdy_now   = fu_ready;
            fu_packet = '0;
            for (int c = 0; c < N; c++) begin
                if (vecs[i].offer[c]) offer(c, {2'(c), seq[c]});
            end
            tick();
            for (int c = 0; c < N; c++) begin
                if (vecs[i].offer[c] && rdy_now[c]) seq[c] = seq[c] + 3'd1;
            end
            expect_state($sformatf("rr%0d", i), vecs[i].exp_valid, vecs[i].exp_rob,
                         vecs[i].exp_gidx, vecs[i].exp_ready);
        end

        // Single push on channel 2: visible exactly two edges later, for one cycle
        fu_packet = '0;
        offer(2, 5'd5);
        tick();
        fu_packet = '0;
        expect_state("single_t", 1'b0, 5'd27, 2'd3, 4'b1111);
        tick();
        expect_state("single_t1", 1'b1, 5'd5, 2'd2, 4'b1111);
        chk("single_result", ex_ic_reg.result, result_of(5'd5));
        chk("single_prn", 32'(ex_ic_reg.dest_prn), 32'd6);
        tick();
        expect_state("single_t2", 1'b0, 5'd5, 2'd2, 4'b1111);

        // Fill channel 1, hold its next offer until a slot frees
        offer(0, 5'd20);
        offer(1, 5'd10);
        tick();
        expect_state("hold1", 1'b0, 5'd5, 2'd2, 4'b1111);
        offer(0, 5'd21);
        offer(1, 5'd11);
        tick();
        expect_state("hold2", 1'b1, 5'd20, 2'd0, 4'b1101);
        fu_packet = '0;
        offer(1, 5'd12);
        tick();
        expect_state("hold3", 1'b1, 5'd10, 2'd1, 4'b1111);
        tick();
        expect_state("hold4", 1'b1, 5'd21, 2'd0, 4'b1101);
        fu_packet = '0;
        tick();
        expect_state("hold5", 1'b1, 5'd11, 2'd1, 4'b1111);
        tick();
        expect_state("hold6", 1'b1, 5'd12, 2'd1, 4'b1111);
        tick();
        expect_state("hold7", 1'b0, 5'd12, 2'd1, 4'b1111);

        // Squash with three packets buffered and a fresh offer on channel 0
        offer(0, 5'd1);
        offer(1, 5'd2);
        offer(3, 5'd3);
        tick();
        expect_state("sq_fill", 1'b0, 5'd12, 2'd1, 4'b1111);
        fu_packet = '0;
        squash    = 1'b1;
        offer(0, 5'd30);
        tick();
        squash    = 1'b0;
        fu_packet = '0;
        expect_state("sq_edge", 1'b0, 5'd12, 2'd1, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_state($sformatf("sq_after%0d", i), 1'b0, 5'd12, 2'd1, 4'b1111);
        end

        // Reset pulse while two channels are full
        offer(1, 5'd4);
        offer(2, 5'd6);
        offer(3, 5'd7);
        tick();
        expect_state("rs_fill1", 1'b0, 5'd12, 2'd1, 4'b1111);
        offer(1, 5'd5);
        offer(2, 5'd8);
        offer(3, 5'd9);
        tick();
        expect_state("rs_fill2", 1'b1, 5'd4, 2'd1, 4'b0011);
        fu_packet = '0;
        reset     = 1'b0;
        tick();
        reset = 1'b1;
        expect_state("rs_pulse", 1'b0, 5'd0, 2'd0, 4'b1111);
        tick();
        expect_state("rs_idle", 1'b0, 5'd0, 2'd0, 4'b1111);
        offer(1, 5'd14);
        offer(3, 5'd15);
        tick();
        fu_packet = '0;
        expect_state("rs_push", 1'b0, 5'd0, 2'd0, 4'b1111);
        tick();
        expect_state("rs_g0", 1'b1, 5'd14, 2'd1, 4'b1111);
        tick();
        expect_state("rs_g1", 1'b1, 5'd15, 2'd3, 4'b1111);
        tick();
        expect_state("rs_g2", 1'b0, 5'd15, 2'd3, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
